// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction RAM arbiter: FSM states, access-owner codes, fetch address check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package imem_arbiter_pkg;

   localparam int FETCH_AW = 32;   // fetch byte-address width
   localparam int CNT_W    = 4;    // wait counter width, covers MAX_WAIT up to 15

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Who was granted the RAM in the previous cycle, i.e. who receives the response now.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LDR   = 2'd2,
      OWN_BAD   = 2'd3
   } owner_t;

   // A fetch is bad when it is not word aligned or points past the end of the RAM.
   function automatic logic fetch_is_bad(input logic [FETCH_AW-1:0] addr, input int addr_w);
      logic [FETCH_AW-1:0] hi;
      hi = addr >> (addr_w + 2);
      return (addr[1:0] != 2'b00) || (hi != '0);
   endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundles the fetch, loader and RAM-side signals of the instruction RAM arbiter.
// Latency: none (wires only).
// Backpressure: gnt/stall flow back to the requesters; the RAM side has none.
interface imem_arbiter_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
);
   import imem_arbiter_pkg::*;

   logic                boot_done;
   // fetch side
   logic                fetch_req;
   logic [FETCH_AW-1:0] fetch_addr;
   logic                fetch_gnt;
   logic [DATA_W-1:0]   fetch_rdata;
   logic                fetch_valid;
   logic                fetch_err;
   logic                fetch_stall;
   // loader side
   logic                ldr_req;
   logic                ldr_we;
   logic [ADDR_W-1:0]   ldr_addr;
   logic [DATA_W-1:0]   ldr_wdata;
   logic                ldr_gnt;
   logic [DATA_W-1:0]   ldr_rdata;
   logic                ldr_ack;
   // RAM side
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_wre;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;

   // Arbiter view.
   modport slave (
      input  boot_done, fetch_req, fetch_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
      output fetch_gnt, fetch_rdata, fetch_valid, fetch_err, fetch_stall,
             ldr_gnt, ldr_rdata, ldr_ack, mem_addr, mem_wre, mem_wdata
   );

   // Requester / RAM environment view.
   modport master (
      output boot_done, fetch_req, fetch_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
      input  fetch_gnt, fetch_rdata, fetch_valid, fetch_err, fetch_stall,
             ldr_gnt, ldr_rdata, ldr_ack, mem_addr, mem_wre, mem_wdata
   );

endinterface

// File: rtl/arb_starve_ctr.sv
// Counts consecutive denied loader cycles, saturating at MAX_WAIT; clears whenever inc_i drops.
// Latency: count visible the cycle after the denial.
// Backpressure: none; the parent compares the count against MAX_WAIT to force a grant.
module arb_starve_ctr
   import imem_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: saturating increment while denied, zero otherwise.
   always_comb begin
      cnt_d = '0;
      if (inc_i) begin
         cnt_d = (cnt_q == CNT_W'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM: loader owns it until boot_done, then fetch first with a starvation guard.
// Latency: grants combinational; rdata/valid/ack/err one cycle after the grant; 1 access per cycle.
// Backpressure: denied requesters see gnt=0 (fetch also gets fetch_stall); loader waits at most MAX_WAIT+1 cycles.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   imem_arbiter_if.slave bus
);
   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              ldr_rd_q, ldr_rd_d;
   logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]  wait_cnt;
   logic              fetch_bad;
   logic              starved;
   logic              wait_inc;
   logic              ldr_gnt;
   logic              fetch_gnt;
   logic              fetch_stall;
   logic              fetch_valid;

   assign fetch_bad = fetch_is_bad(bus.fetch_addr, ADDR_W);
   assign starved   = (wait_cnt == CNT_W'(MAX_WAIT));
   assign wait_inc  = (state_q == ST_RUN) & bus.ldr_req & ~ldr_gnt;

   arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_ctr (
      .clock (clock),
      .reset (reset),
      .inc_i (wait_inc),
      .cnt_o (wait_cnt)
   );

   // Grant decision: loader only during boot, fetch first in run unless the loader is starved
   // or the fetch is bad. Grants are held off while reset is asserted so nothing reaches the RAM.
   always_comb begin
      ldr_gnt     = 1'b0;
      fetch_gnt   = 1'b0;
      fetch_stall = 1'b1;
      if (reset) begin
         if (state_q == ST_BOOT) begin
            ldr_gnt = bus.ldr_req;
         end else begin
            ldr_gnt     = bus.ldr_req & (~bus.fetch_req | starved | fetch_bad);
            fetch_gnt   = bus.fetch_req & ~ldr_gnt;
            fetch_stall = bus.fetch_req & ~fetch_gnt;
         end
      end
   end

   // Next-state: boot exit, response owner, RAM address hold and loader read-data capture.
   always_comb begin
      state_d = state_q;
      if ((state_q == ST_BOOT) && bus.boot_done) begin
         state_d = ST_RUN;
      end

      owner_d = OWN_NONE;
      if (ldr_gnt) begin
         owner_d = OWN_LDR;
      end else if (fetch_gnt) begin
         owner_d = fetch_bad ? OWN_BAD : OWN_FETCH;
      end

      ldr_rd_d = ldr_gnt & ~bus.ldr_we;

      // A bad fetch makes no RAM access, so the address is left where it was.
      mem_addr_d = mem_addr_q;
      if (ldr_gnt) begin
         mem_addr_d = bus.ldr_addr;
      end else if (fetch_gnt & ~fetch_bad) begin
         mem_addr_d = bus.fetch_addr[ADDR_W+1:2];
      end

      // Loader read data is taken straight from the RAM in the ack cycle and held afterwards.
      ldr_rdata_d = ldr_rdata_q;
      if ((owner_q == OWN_LDR) && ldr_rd_q) begin
         ldr_rdata_d = bus.mem_rdata;
      end
   end

   // FSM and response-tracking registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_BOOT;
         owner_q     <= OWN_NONE;
         ldr_rd_q    <= 1'b0;
         ldr_rdata_q <= '0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ldr_rd_q    <= ldr_rd_d;
         ldr_rdata_q <= ldr_rdata_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign fetch_valid     = (owner_q == OWN_FETCH);

   assign bus.fetch_gnt   = fetch_gnt;
   assign bus.fetch_stall = fetch_stall;
   assign bus.fetch_valid = fetch_valid;
   assign bus.fetch_err   = (owner_q == OWN_BAD);
   assign bus.fetch_rdata = fetch_valid ? bus.mem_rdata : '0;
   assign bus.ldr_gnt     = ldr_gnt;
   assign bus.ldr_ack     = (owner_q == OWN_LDR);
   assign bus.ldr_rdata   = ldr_rdata_d;
   assign bus.mem_addr    = mem_addr_d;
   assign bus.mem_wre     = ldr_gnt & bus.ldr_we;
   assign bus.mem_wdata   = bus.ldr_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed boot/priority/starvation/bad-fetch/reset cases, then random traffic.
// Latency: n/a.
// Backpressure: loader requests are held until granted; fetch requests may come and go.
module tb_imem_arbiter;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 1 << ADDR_W;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   imem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous single-port RAM: read data appears one cycle after the address.
   logic [DATA_W-1:0] ram [DEPTH] = '{default: '0};
   always @(posedge clock) begin
      if (bus.mem_wre) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int n_checks = 0;
   int n_errors = 0;

   // Stimulus variables.
   logic              drv_boot, drv_freq, drv_lreq, drv_lwe;
   logic [31:0]       drv_faddr;
   logic [ADDR_W-1:0] drv_laddr;
   logic [DATA_W-1:0] drv_lwdata;

   // Reference model state.
   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                m_boot;
   int                m_wait;        // consecutive denied loader cycles in run
   int                m_pend_f;      // 0 none, 1 good fetch, 2 bad fetch
   logic [DATA_W-1:0] m_pend_fdata;
   bit                m_pend_l, m_pend_lrd;
   logic [DATA_W-1:0] m_pend_ldata, m_ldr_rdata;
   logic [ADDR_W-1:0] m_mem_addr;
   int                m_age;         // cycles the current loader request has been denied (DUT view)
   bit                m_last_lgnt;
   int                gnt_at;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic apply();
      bus.boot_done  = drv_boot;
      bus.fetch_req  = drv_freq;
      bus.fetch_addr = drv_faddr;
      bus.ldr_req    = drv_lreq;
      bus.ldr_we     = drv_lwe;
      bus.ldr_addr   = drv_laddr;
      bus.ldr_wdata  = drv_lwdata;
   endtask

   task automatic set_idle();
      drv_boot   = 1'b0;
      drv_freq   = 1'b0;
      drv_faddr  = '0;
      drv_lreq   = 1'b0;
      drv_lwe    = 1'b0;
      drv_laddr  = '0;
      drv_lwdata = '0;
   endtask

   task automatic ldr_op(input bit we, input int addr, input logic [DATA_W-1:0] data);
      drv_lreq   = 1'b1;
      drv_lwe    = we;
      drv_laddr  = ADDR_W'(addr);
      drv_lwdata = data;
   endtask

   task automatic model_reset();
      m_boot       = 1'b1;
      m_wait       = 0;
      m_pend_f     = 0;
      m_pend_fdata = '0;
      m_pend_l     = 1'b0;
      m_pend_lrd   = 1'b0;
      m_pend_ldata = '0;
      m_ldr_rdata  = '0;
      m_mem_addr   = '0;
      m_age        = 0;
      m_last_lgnt  = 1'b0;
   endtask

   // One cycle: drive at the falling edge, compare 1 unit later, advance the model.
   task automatic step();
      bit                bad, eg_l, eg_f, e_stall;
      logic [ADDR_W-1:0] e_addr, f_idx;
      @(negedge clock);
      apply();
      #1;
      // responses to last cycle's grant
      if (m_pend_l && m_pend_lrd) m_ldr_rdata = m_pend_ldata;
      check("fetch_valid", 32'(bus.fetch_valid), 32'(m_pend_f == 1));
      check("fetch_err",   32'(bus.fetch_err),   32'(m_pend_f == 2));
      check("fetch_rdata", bus.fetch_rdata, (m_pend_f == 1) ? m_pend_fdata : 32'd0);
      check("ldr_ack",     32'(bus.ldr_ack),     32'(m_pend_l));
      check("ldr_rdata",   bus.ldr_rdata, m_ldr_rdata);

      // this cycle's arbitration
      bad   = (drv_faddr % 4 != 0) || (drv_faddr >= 32'(4 * DEPTH));
      f_idx = ADDR_W'(drv_faddr / 4);
      if (m_boot) begin
         eg_l    = drv_lreq;
         eg_f    = 1'b0;
         e_stall = 1'b1;
      end else begin
         eg_l    = drv_lreq && (!drv_freq || bad || m_wait >= MAX_WAIT);
         eg_f    = drv_freq && !eg_l;
         e_stall = drv_freq && !eg_f;
      end
      if (eg_l)              e_addr = drv_laddr;
      else if (eg_f && !bad) e_addr = f_idx;
      else                   e_addr = m_mem_addr;

      check("ldr_gnt",     32'(bus.ldr_gnt),     32'(eg_l));
      check("fetch_gnt",   32'(bus.fetch_gnt),   32'(eg_f));
      check("fetch_stall", 32'(bus.fetch_stall), 32'(e_stall));
      check("mem_wre",     32'(bus.mem_wre),     32'(eg_l && drv_lwe));
      check("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
      if (eg_l && drv_lwe) check("mem_wdata", bus.mem_wdata, drv_lwdata);
      if (bus.ldr_gnt && drv_lreq)
         check("ldr_wait_bound", 32'(m_age + 1 <= MAX_WAIT + 1), 32'd1);

      // advance model
      m_age        = (drv_lreq && !bus.ldr_gnt) ? m_age + 1 : 0;
      m_pend_f     = eg_f ? (bad ? 2 : 1) : 0;
      m_pend_fdata = ref_mem[f_idx];
      m_pend_l     = eg_l;
      m_pend_lrd   = eg_l && !drv_lwe;
      m_pend_ldata = ref_mem[drv_laddr];
      if (eg_l && drv_lwe) ref_mem[drv_laddr] = drv_lwdata;
      m_mem_addr   = e_addr;
      m_wait       = (!m_boot && drv_lreq && !eg_l) ? m_wait + 1 : 0;
      if (m_boot && drv_boot) m_boot = 1'b0;
      m_last_lgnt  = eg_l;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      set_idle();
      apply();
      model_reset();

      // reset values while reset is held
      repeat (2) @(negedge clock);
      #1;
      check("rst_fetch_stall", 32'(bus.fetch_stall), 32'd1);
      check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      check("rst_fetch_err",   32'(bus.fetch_err),   32'd0);
      check("rst_ldr_ack",     32'(bus.ldr_ack),     32'd0);
      check("rst_mem_wre",     32'(bus.mem_wre),     32'd0);
      check("rst_fetch_rdata", bus.fetch_rdata, 32'd0);
      check("rst_ldr_rdata",   bus.ldr_rdata,   32'd0);
      reset = 1'b1;

      // 1: loader writes in BOOT, fetch is held off
      set_idle(); ldr_op(1, 3, 32'hDEADBEEF); drv_freq = 1'b1; drv_faddr = 32'h0C; step();
      check("t1_boot_fetch_gnt", 32'(bus.fetch_gnt),   32'd0);
      check("t1_boot_stall",     32'(bus.fetch_stall), 32'd1);
      check("t1_boot_ldr_gnt",   32'(bus.ldr_gnt),     32'd1);
      set_idle(); ldr_op(1, 4, 32'h12345678); drv_freq = 1'b1; drv_faddr = 32'h0C; step();
      check("t1_ack_w3", 32'(bus.ldr_ack), 32'd1);
      set_idle(); step();
      check("t1_ack_w4", 32'(bus.ldr_ack), 32'd1);

      // 2: leave BOOT, fetch word 3
      set_idle(); drv_boot = 1'b1; step();
      set_idle(); drv_freq = 1'b1; drv_faddr = 32'h0C; step();
      check("t2_fetch_gnt", 32'(bus.fetch_gnt), 32'd1);
      set_idle(); step();
      check("t2_fetch_valid", 32'(bus.fetch_valid), 32'd1);
      check("t2_fetch_rdata", bus.fetch_rdata, 32'hDEADBEEF);

      // 3: fetch hogs the RAM; loader read forced through on its MAX_WAIT+1-th cycle
      gnt_at = 0;
      for (int i = 1; i <= MAX_WAIT + 4 && gnt_at == 0; i++) begin
         set_idle(); drv_freq = 1'b1; drv_faddr = 32'h10; ldr_op(0, 4, '0); step();
         check("t3_stall", 32'(bus.fetch_stall), 32'(i == MAX_WAIT + 1));
         if (bus.ldr_gnt) gnt_at = i;
      end
      check("t3_gnt_cycle", 32'(gnt_at), 32'(MAX_WAIT + 1));
      set_idle(); step();
      check("t3_ldr_ack",   32'(bus.ldr_ack), 32'd1);
      check("t3_ldr_rdata", bus.ldr_rdata, 32'h12345678);

      // 4: misaligned and out-of-range fetches
      set_idle(); drv_freq = 1'b1; drv_faddr = 32'h02; step();
      check("t4_mis_gnt", 32'(bus.fetch_gnt), 32'd1);
      check("t4_mis_wre", 32'(bus.mem_wre),   32'd0);
      set_idle(); drv_freq = 1'b1; drv_faddr = 32'h200; step();
      check("t4_mis_err",   32'(bus.fetch_err),   32'd1);
      check("t4_mis_valid", 32'(bus.fetch_valid), 32'd0);
      check("t4_oor_wre",   32'(bus.mem_wre),     32'd0);
      set_idle(); step();
      check("t4_oor_err",   32'(bus.fetch_err),   32'd1);
      check("t4_oor_valid", 32'(bus.fetch_valid), 32'd0);
      check("t4_oor_rdata", bus.fetch_rdata, 32'd0);
      check("t4_ram3", ram[3], 32'hDEADBEEF);
      check("t4_ram4", ram[4], 32'h12345678);

      // 5: reset in the middle of a granted loader write
      set_idle(); ldr_op(1, 9, 32'hBAD0BAD0);
      @(negedge clock);
      apply();
      #1;
      check("t5_gnt_before_rst", 32'(bus.ldr_gnt), 32'd1);
      reset = 1'b0;
      #1;
      check("t5_rst_ldr_gnt", 32'(bus.ldr_gnt),     32'd0);
      check("t5_rst_wre",     32'(bus.mem_wre),     32'd0);
      check("t5_rst_stall",   32'(bus.fetch_stall), 32'd1);
      check("t5_rst_ack",     32'(bus.ldr_ack),     32'd0);
      check("t5_rst_valid",   32'(bus.fetch_valid), 32'd0);
      check("t5_rst_ldr_rd",  bus.ldr_rdata, 32'd0);
      @(posedge clock);
      #1;
      check("t5_no_ack", 32'(bus.ldr_ack), 32'd0);
      set_idle();
      apply();
      model_reset();
      @(negedge clock);
      #1 reset = 1'b1;
      // back in BOOT: fetch denied, and word 9 was never written
      set_idle(); ldr_op(0, 9, '0); drv_freq = 1'b1; drv_faddr = 32'h0; step();
      check("t5_boot_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
      set_idle(); drv_boot = 1'b1; step();
      check("t5_ram9_unwritten", bus.ldr_rdata, 32'd0);

      // 6: random traffic in RUN against the model
      set_idle();
      for (int c = 0; c < 2000; c++) begin
         drv_boot = ($urandom_range(0, 15) == 0);
         drv_freq = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 15))
            0:       drv_faddr = $urandom();
            1:       drv_faddr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            default: drv_faddr = 32'($urandom_range(0, DEPTH - 1)) << 2;
         endcase
         if (!drv_lreq || m_last_lgnt) begin
            if ($urandom_range(0, 2) == 0) ldr_op($urandom_range(0, 1) == 1,
                                                  int'($urandom_range(0, DEPTH - 1)), $urandom());
            else drv_lreq = 1'b0;
         end
         step();
      end
      set_idle();
      repeat (3) step();
      for (int i = 0; i < DEPTH; i++) check("final_ram", ram[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
